// File: rtl/lz4_out_packer.sv
// Repacks 1-4 byte LZ4 encoder FIFO entries into a dense little-endian 32-bit
// valid/ready stream; flush drains the FIFO, tags the final word and reports the byte total.
module lz4_out_packer #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_empty,
    output logic             in_en,
    input  logic [33:0]      in_data,
    input  logic             in_valid,
    input  logic             flush,
    output logic [31:0]      o_data,
    output logic [3:0]       o_keep,
    output logic             o_valid,
    output logic             o_last,
    input  logic             o_ready,
    output logic             done,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LAST, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [6:0][7:0]  acc_q, acc_sh, acc_d;
    logic [2:0]       cnt_q, cnt_sh, cnt_d;
    logic             rd_pend_q;
    logic             hs, shift, accept;
    logic [2:0]       nbytes;
    logic [3:0][7:0]  din_m;
    logic [CNT_W-1:0] bc_d;
    logic             in_en_d, o_valid_d, o_last_d, done_d;
    logic [3:0]       o_keep_d;
    logic [3:0][7:0]  o_data_d;

    function automatic logic [3:0] keep_of(input logic [2:0] n);
        case (n)
            3'd0:    keep_of = 4'h0;
            3'd1:    keep_of = 4'h1;
            3'd2:    keep_of = 4'h3;
            3'd3:    keep_of = 4'h7;
            default: keep_of = 4'hF;
        endcase
    endfunction

    // Only single-cycle read latency exists; data is accepted solely for a read we issued.
    assign hs     = o_valid && o_ready;
    assign shift  = hs && !o_last;
    assign accept = in_valid && rd_pend_q && (RD_LAT == 1);

    // Count code 00 means a full 4-byte entry; bytes above the count are zeroed
    // so the buffer stays clean above acc_cnt and appends can simply OR in.
    always_comb begin
        nbytes = (in_data[33:32] == 2'b00) ? 3'd4 : {1'b0, in_data[33:32]};
        din_m  = '0;
        for (int i = 0; i < 4; i++)
            din_m[i] = (3'(i) < nbytes) ? in_data[8*i +: 8] : 8'h00;
    end

    always_comb begin
        acc_sh = shift ? {32'h0, acc_q[6:4]} : acc_q;
        cnt_sh = shift ? (cnt_q - 3'd4) : cnt_q;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_sh;
        cnt_d   = cnt_sh;
        bc_d    = byte_count;
        if (accept) begin
            acc_d = acc_sh | ({24'h0, din_m} << {cnt_sh, 3'b000});
            cnt_d = cnt_sh + nbytes;
            bc_d  = byte_count + CNT_W'(nbytes);
        end
        case (state_q)
            S_RUN:   if (flush) state_d = S_DRAIN;
            // in-flight data is already folded into cnt_d when it lands this cycle
            S_DRAIN: if (in_empty && !in_en && (cnt_d < 3'd4)) state_d = S_LAST;
            S_LAST:  if (hs) state_d = S_DONE;
            S_DONE: begin
                state_d = S_RUN;
                acc_d   = '0;
                cnt_d   = '0;
                bc_d    = '0;
            end
            default: state_d = S_RUN;
        endcase
    end

    // in_en is registered, so the guard uses next-cycle occupancy; with one read
    // in flight at most the buffer peaks at 3+4=7 bytes.
    always_comb begin
        in_en_d = !in_en && !in_empty && (cnt_d <= 3'd3) &&
                  ((state_d == S_RUN) || (state_d == S_DRAIN));
    end

    // Outputs are derived from next-state buffer contents; a stalled word stays put
    // because appends land above byte 3 while acc_cnt >= 4.
    always_comb begin
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
        o_keep_d  = 4'h0;
        o_data_d  = '0;
        done_d    = 1'b0;
        case (state_d)
            S_RUN, S_DRAIN: begin
                if (cnt_d >= 3'd4) begin
                    o_valid_d = 1'b1;
                    o_keep_d  = 4'hF;
                    o_data_d  = acc_d[3:0];
                end
            end
            S_LAST: begin
                o_valid_d = 1'b1;
                o_last_d  = 1'b1;
                o_keep_d  = keep_of(cnt_d);
                for (int i = 0; i < 4; i++)
                    o_data_d[i] = o_keep_d[i] ? acc_d[i] : 8'h00;
            end
            S_DONE:  done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            acc_q      <= '0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            in_en      <= 1'b0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_keep     <= 4'h0;
            o_data     <= 32'h0;
            done       <= 1'b0;
            byte_count <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= in_en;
            in_en      <= in_en_d;
            o_valid    <= o_valid_d;
            o_last     <= o_last_d;
            o_keep     <= o_keep_d;
            o_data     <= o_data_d;
            done       <= done_d;
            byte_count <= bc_d;
        end
    end

endmodule

// File: tb/tb_lz4_out_packer.sv
// Directed bench for lz4_out_packer: FIFO model with 1-cycle read latency, output
// capture, hold-stability and read-guard checks, and per-scenario expected words.
module tb_lz4_out_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_empty = 1'b1;
    logic        in_en;
    logic [33:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_valid, o_last;
    logic        o_ready = 1'b1;
    logic        done;
    logic [31:0] byte_count;

    always #5 clk = ~clk;

    lz4_out_packer #(.RD_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_empty(in_empty), .in_en(in_en),
        .in_data(in_data), .in_valid(in_valid), .flush(flush),
        .o_data(o_data), .o_keep(o_keep), .o_valid(o_valid), .o_last(o_last),
        .o_ready(o_ready), .done(done), .byte_count(byte_count)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] fifo_q[$];
    logic [36:0] cap_q[$];          // {last, keep, data}
    int          done_seen = 0;
    logic [31:0] done_bc = '0;

    logic        pend = 1'b0;
    logic [33:0] pend_data = '0;
    int          mdl_cnt = 0, add_prev = 0, sub_prev = 0;
    logic        rst_prev = 1'b1, stall_prev = 1'b0;
    logic [36:0] held = '0;

    // Monitor + FIFO model on the falling edge: occupancy model, stall/guard checks,
    // capture, then drive the read response one cycle after in_en was sampled.
    always @(negedge clk) begin
        int nb;
        if (rst_prev) mdl_cnt = 0;
        else          mdl_cnt = mdl_cnt + add_prev - sub_prev;
        if (stall_prev && !rst_prev) begin
            n_tests++;
            if ({o_last, o_keep, o_data} !== held) begin
                n_fail++;
                $display("FAIL hold_stable: got %h want %h", {o_last, o_keep, o_data}, held);
            end
        end
        if (in_en && !rst) begin
            n_tests++;
            if (mdl_cnt - ((o_valid && o_ready && !o_last) ? 4 : 0) > 3) begin
                n_fail++;
                $display("FAIL in_en_guard: occupancy %0d want <= 3", mdl_cnt);
            end
        end
        if (o_valid && o_ready && !rst) cap_q.push_back({o_last, o_keep, o_data});
        if (done && !rst) begin
            done_seen++;
            done_bc = byte_count;
        end
        in_valid = pend;
        in_data  = pend ? pend_data : 34'h0;
        if (in_en && fifo_q.size() > 0) begin
            pend = 1'b1;
            pend_data = fifo_q.pop_front();
        end else begin
            pend = 1'b0;
        end
        in_empty = (fifo_q.size() == 0);
        nb = (in_data[33:32] == 2'b00) ? 4 : int'(in_data[33:32]);
        add_prev   = (in_valid && !rst_prev) ? nb : 0;
        sub_prev   = (o_valid && o_ready) ? (o_last ? mdl_cnt : 4) : 0;
        stall_prev = o_valid && !o_ready;
        held       = {o_last, o_keep, o_data};
        rst_prev   = rst;
    end

    task automatic pulse_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got[7];
        string       nm[7];
        rst = 1'b1; o_ready = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = '{32'(o_valid), 32'(o_last), 32'(o_keep), o_data, 32'(done), byte_count, 32'(in_en)};
        nm  = '{"rst_o_valid", "rst_o_last", "rst_o_keep", "rst_o_data", "rst_done", "rst_byte_count", "rst_in_en"};
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (got[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL %s: got %h want 0", nm[i], got[i]);
            end
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_full_words();
        logic [36:0] exp[5];
        int d0 = done_seen;
        int t = 0;
        cap_q.delete();
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back({2'b00, 32'h03020100 + 32'h04040404 * i});
            exp[i] = {1'b0, 4'hF, 32'h03020100 + 32'h04040404 * i};
        end
        exp[4] = {1'b1, 4'h0, 32'h0};
        pulse_flush();
        while (done_seen == d0 && t < 2000) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (done_seen != d0 + 1) begin n_fail++; $display("FAIL full_done: pulses %0d want 1", done_seen - d0); end
        n_tests++;
        if (cap_q.size() != 5) begin n_fail++; $display("FAIL full_words_count: got %0d want 5", cap_q.size()); end
        for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
            n_tests++;
            if (cap_q[i] !== exp[i]) begin n_fail++; $display("FAIL full_word%0d: got %h want %h", i, cap_q[i], exp[i]); end
        end
        n_tests++;
        if (done_bc !== 32'd16) begin n_fail++; $display("FAIL full_byte_count: got %0d want 16", done_bc); end
        n_tests++;
        if (byte_count !== 32'd0) begin n_fail++; $display("FAIL full_count_cleared: got %0d want 0", byte_count); end
    endtask

    task automatic test_mixed();
        logic [36:0] exp[2];
        int d0 = done_seen;
        int t = 0;
        cap_q.delete();
        o_ready = 1'b1;
        fifo_q.push_back({2'b01, 32'h000000AA});
        fifo_q.push_back({2'b11, 32'h00DDCCBB});
        fifo_q.push_back({2'b10, 32'h0000FFEE});
        exp[0] = {1'b0, 4'hF, 32'hDDCCBBAA};
        exp[1] = {1'b1, 4'h3, 32'h0000FFEE};
        pulse_flush();
        while (done_seen == d0 && t < 2000) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (cap_q.size() != 2) begin n_fail++; $display("FAIL mixed_count: got %0d want 2", cap_q.size()); end
        for (int i = 0; i < 2 && i < cap_q.size(); i++) begin
            n_tests++;
            if (cap_q[i] !== exp[i]) begin n_fail++; $display("FAIL mixed_word%0d: got %h want %h", i, cap_q[i], exp[i]); end
        end
        n_tests++;
        if (done_bc !== 32'd6) begin n_fail++; $display("FAIL mixed_byte_count: got %0d want 6", done_bc); end
    endtask

    task automatic test_stall_1b();
        logic [36:0] exp[7];
        logic [7:0]  b;
        int d0 = done_seen;
        cap_q.delete();
        o_ready = 1'b1;
        for (int i = 0; i < 24; i++) fifo_q.push_back({2'b01, 24'h0, 8'(8'h40 + i)});
        for (int w = 0; w < 6; w++) begin
            exp[w] = {1'b0, 4'hF, 32'h0};
            for (int k = 0; k < 4; k++) begin
                b = 8'(8'h40 + 4 * w + k);
                exp[w][8*k +: 8] = b;
            end
        end
        exp[6] = {1'b1, 4'h0, 32'h0};
        for (int t = 0; t < 3000 && done_seen == d0; t++) begin
            @(posedge clk);
            #1;
            o_ready = ~o_ready;
            flush   = (t == 0);
        end
        flush = 1'b0;
        o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (cap_q.size() != 7) begin n_fail++; $display("FAIL stall_count: got %0d want 7", cap_q.size()); end
        for (int i = 0; i < 7 && i < cap_q.size(); i++) begin
            n_tests++;
            if (cap_q[i] !== exp[i]) begin n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, cap_q[i], exp[i]); end
        end
        n_tests++;
        if (done_bc !== 32'd24) begin n_fail++; $display("FAIL stall_byte_count: got %0d want 24", done_bc); end
    endtask

    task automatic test_flush_inflight();
        logic [36:0] exp[2];
        int d0 = done_seen;
        int t = 0;
        bit seen = 0;
        cap_q.delete();
        o_ready = 1'b1;
        fifo_q.push_back({2'b10, 32'h0000BBAA});
        repeat (6) @(posedge clk);
        #1;
        fifo_q.push_back({2'b11, 32'h00332211});
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = in_en;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL inflight_read_issue: in_en 0 want 1"); end
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        exp[0] = {1'b0, 4'hF, 32'h2211BBAA};
        exp[1] = {1'b1, 4'h1, 32'h00000033};
        while (done_seen == d0 && t < 2000) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (cap_q.size() != 2) begin n_fail++; $display("FAIL inflight_count: got %0d want 2", cap_q.size()); end
        for (int i = 0; i < 2 && i < cap_q.size(); i++) begin
            n_tests++;
            if (cap_q[i] !== exp[i]) begin n_fail++; $display("FAIL inflight_word%0d: got %h want %h", i, cap_q[i], exp[i]); end
        end
        n_tests++;
        if (done_bc !== 32'd5) begin n_fail++; $display("FAIL inflight_byte_count: got %0d want 5", done_bc); end
    endtask

    task automatic test_reset_midstream();
        logic [36:0] exp[2];
        int d0;
        int t = 0;
        bit seen = 0;
        o_ready = 1'b0;
        fifo_q.push_back({2'b01, 32'h000000A5});
        fifo_q.push_back({2'b00, 32'h0D0C0B0A});
        fifo_q.push_back({2'b00, 32'h11111111});
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (byte_count !== 32'd5) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 5", byte_count); end
        n_tests++;
        if ({o_valid, o_data} !== {1'b1, 32'h0C0B0AA5}) begin
            n_fail++; $display("FAIL mid_pre_word: got %h want %h", {o_valid, o_data}, {1'b1, 32'h0C0B0AA5});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", o_valid); end
        n_tests++;
        if (byte_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", byte_count); end
        // Reset again while the leftover entry's read is in flight; its data must be dropped.
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = in_en;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL mid_read_issue: in_en 0 want 1"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if ({o_valid, byte_count} !== 33'h0) begin
            n_fail++; $display("FAIL mid_inflight_dropped: valid %b count %0d want 0 0", o_valid, byte_count);
        end
        cap_q.delete();
        d0 = done_seen;
        o_ready = 1'b1;
        fifo_q.push_back({2'b00, 32'hDEADBEEF});
        exp[0] = {1'b0, 4'hF, 32'hDEADBEEF};
        exp[1] = {1'b1, 4'h0, 32'h0};
        pulse_flush();
        while (done_seen == d0 && t < 2000) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (cap_q.size() != 2) begin n_fail++; $display("FAIL mid_after_count: got %0d want 2", cap_q.size()); end
        for (int i = 0; i < 2 && i < cap_q.size(); i++) begin
            n_tests++;
            if (cap_q[i] !== exp[i]) begin n_fail++; $display("FAIL mid_after_word%0d: got %h want %h", i, cap_q[i], exp[i]); end
        end
        n_tests++;
        if (done_bc !== 32'd4) begin n_fail++; $display("FAIL mid_after_byte_count: got %0d want 4", done_bc); end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_mixed();
        test_stall_1b();
        test_flush_inflight();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
